// File: rtl/sfu_seq_ctrl_if.sv
// Bundle of the three data paths the sequencer touches: psum SRAM read port,
// sfu stream in/out, and output SRAM write port. master = sequencer side.
interface sfu_seq_ctrl_if #(
   parameter int psum_bw = 16,
   parameter int addr_bw = 11
);
   logic               mem_ren;
   logic [addr_bw-1:0] mem_addr;
   logic [psum_bw-1:0] mem_rdata;
   logic               sfu_valid_in;
   logic [psum_bw-1:0] sfu_psum_in;
   logic               sfu_valid_out;
   logic [psum_bw-1:0] sfu_psum_out;
   logic               out_wen;
   logic [addr_bw-1:0] out_addr;
   logic [psum_bw-1:0] out_wdata;

   modport master (
      output mem_ren, mem_addr,
      input  mem_rdata,
      output sfu_valid_in, sfu_psum_in,
      input  sfu_valid_out, sfu_psum_out,
      output out_wen, out_addr, out_wdata
   );

   modport slave (
      input  mem_ren, mem_addr,
      output mem_rdata,
      input  sfu_valid_in, sfu_psum_in,
      output sfu_valid_out, sfu_psum_out,
      input  out_wen, out_addr, out_wdata
   );
endinterface

// File: rtl/sfu_seq_ctrl.sv
// Streams psum bursts from SRAM into the shared sfu and writes results back.
// Optional cycle counter port perf_cycles enabled by SFU_SEQ_CTRL_PERF_EN.
//
// state | meaning
// IDLE  | waiting for start; config latched on start
// READ  | issuing psum reads for the current output, one word per cycle
// GAP   | one idle read cycle so the sfu sees the burst end
// DRAIN | all reads issued; waiting for the remaining write-backs
// FIN   | last cycle of the run; done pulses on the following cycle
module sfu_seq_ctrl #(
   parameter int psum_bw = 16,
   parameter int addr_bw = 11,
   parameter int cnt_bw  = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [cnt_bw-1:0]  num_out,
   input  logic [cnt_bw-1:0]  num_acc,
   input  logic [addr_bw-1:0] psum_base,
   input  logic [addr_bw-1:0] out_base,
   output logic               busy,
   output logic               done,
   sfu_seq_ctrl_if.master     bus
`ifdef SFU_SEQ_CTRL_PERF_EN
   ,
   output logic [31:0]        perf_cycles
`endif
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READ  = 3'd1,
      S_GAP   = 3'd2,
      S_DRAIN = 3'd3,
      S_FIN   = 3'd4
   } state_t;

   state_t             state, state_n;
   logic               accept;
   logic               mem_ren;
   logic               wr_fire;
   logic               vld_q;
   logic               out_wen_q;
   logic [cnt_bw-1:0]  cfg_num_out, cfg_num_acc;
   logic [cnt_bw-1:0]  k_cnt, o_cnt, wr_cnt;
   logic [addr_bw-1:0] cfg_out_base, rd_addr, wr_addr_q;
   logic [psum_bw-1:0] wdata_q;

   always_comb begin
      state_n = state;
      accept  = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               accept = 1'b1;
               if (num_out == '0 || num_acc == '0) state_n = S_FIN;
               else                                state_n = S_READ;
            end
         end
         S_READ:  if (k_cnt == cfg_num_acc - cnt_bw'(1)) state_n = S_GAP;
         S_GAP:   state_n = (o_cnt == cfg_num_out - cnt_bw'(1)) ? S_DRAIN : S_READ;
         S_DRAIN: if (wr_cnt == cfg_num_out) state_n = S_FIN;
         S_FIN:   state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   assign mem_ren = (state == S_READ);
   // Results arriving while idle belong to no run and are dropped.
   assign wr_fire = bus.sfu_valid_out & busy;

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_IDLE;
         busy         <= 1'b0;
         done         <= 1'b0;
         vld_q        <= 1'b0;
         out_wen_q    <= 1'b0;
         cfg_num_out  <= '0;
         cfg_num_acc  <= '0;
         cfg_out_base <= '0;
         rd_addr      <= '0;
         k_cnt        <= '0;
         o_cnt        <= '0;
         wr_cnt       <= '0;
         wr_addr_q    <= '0;
         wdata_q      <= '0;
      end else begin
         state     <= state_n;
         done      <= (state == S_FIN);
         vld_q     <= mem_ren;
         out_wen_q <= wr_fire;
         if (state == S_READ) begin
            rd_addr <= rd_addr + addr_bw'(1);
            k_cnt   <= k_cnt + cnt_bw'(1);
         end
         if (state == S_GAP) begin
            k_cnt <= '0;
            o_cnt <= o_cnt + cnt_bw'(1);
         end
         if (wr_fire) begin
            wdata_q   <= bus.sfu_psum_out;
            wr_addr_q <= cfg_out_base + addr_bw'(wr_cnt);
            wr_cnt    <= wr_cnt + cnt_bw'(1);
         end
         if (accept) begin
            cfg_num_out  <= num_out;
            cfg_num_acc  <= num_acc;
            cfg_out_base <= out_base;
            rd_addr      <= psum_base;
            k_cnt        <= '0;
            o_cnt        <= '0;
            wr_cnt       <= '0;
            busy         <= 1'b1;
         end else if (state == S_FIN) begin
            busy <= 1'b0;
         end
      end
   end

   assign bus.mem_ren      = mem_ren;
   assign bus.mem_addr     = mem_ren ? rd_addr : '0;
   assign bus.sfu_valid_in = vld_q;
   // Read data lands one cycle after mem_ren, aligned with the delayed valid.
   assign bus.sfu_psum_in  = bus.mem_rdata;
   assign bus.out_wen      = out_wen_q;
   assign bus.out_addr     = wr_addr_q;
   assign bus.out_wdata    = wdata_q;

`ifdef SFU_SEQ_CTRL_PERF_EN
   logic [31:0] perf_q;

   always_ff @(posedge clk) begin
      if (reset)       perf_q <= '0;
      else if (accept) perf_q <= '0;
      else if (busy)   perf_q <= perf_q + 32'd1;
   end

   assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_sfu_seq_ctrl.sv
// Directed bench for sfu_seq_ctrl with psum SRAM and sfu (accumulate + ReLU) models.
module tb_sfu_seq_ctrl;
   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [7:0]  num_out, num_acc;
   logic [10:0] psum_base, out_base;
   logic        busy, done;
`ifdef SFU_SEQ_CTRL_PERF_EN
   logic [31:0] perf_cycles;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sfu_seq_ctrl_if #(.psum_bw(16), .addr_bw(11)) bus ();

   sfu_seq_ctrl #(.psum_bw(16), .addr_bw(11), .cnt_bw(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .num_out   (num_out),
      .num_acc   (num_acc),
      .psum_base (psum_base),
      .out_base  (out_base),
      .busy      (busy),
      .done      (done),
      .bus       (bus)
`ifdef SFU_SEQ_CTRL_PERF_EN
      ,
      .perf_cycles (perf_cycles)
`endif
   );

   logic [15:0] mem [0:2047];

   always @(posedge clk)
      if (bus.mem_ren) bus.mem_rdata <= mem[bus.mem_addr];

   logic [15:0] sfu_acc;
   logic        sfu_prev;

   always @(posedge clk) begin
      if (reset) begin
         sfu_acc           <= '0;
         sfu_prev          <= 1'b0;
         bus.sfu_valid_out <= 1'b0;
         bus.sfu_psum_out  <= '0;
      end else begin
         sfu_prev          <= bus.sfu_valid_in;
         bus.sfu_valid_out <= 1'b0;
         if (bus.sfu_valid_in) begin
            sfu_acc <= sfu_acc + bus.sfu_psum_in;
         end else if (sfu_prev) begin
            bus.sfu_valid_out <= 1'b1;
            bus.sfu_psum_out  <= sfu_acc[15] ? 16'h0000 : sfu_acc;
            sfu_acc           <= '0;
         end
      end
   end

   logic [10:0] exp_raddr_q [$];
   logic [26:0] exp_wr_q [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   int   rises_total = 0, hi_run = 0, lo_run = 0;
   int   busy_total = 0, done_total = 0, wr_total = 0, ren_total = 0;
   logic prev_vi = 1'b0;
   int   exp_acc = 0;
   int   op_first_rise = 0;
   logic gap_chk_en = 1'b0;

   always @(negedge clk) begin
      if (bus.mem_ren) begin
         ren_total <= ren_total + 1;
         chk("rd_pending", 32'(exp_raddr_q.size() != 0), 32'd1);
         if (exp_raddr_q.size() != 0)
            chk("rd_addr", 32'(bus.mem_addr), 32'(exp_raddr_q.pop_front()));
      end
      if (bus.out_wen) begin
         wr_total <= wr_total + 1;
         chk("wr_pending", 32'(exp_wr_q.size() != 0), 32'd1);
         if (exp_wr_q.size() != 0) begin
            chk("wr_addr", 32'(bus.out_addr), 32'(exp_wr_q[0][26:16]));
            chk("wr_data", 32'(bus.out_wdata), 32'(exp_wr_q[0][15:0]));
            void'(exp_wr_q.pop_front());
         end
      end
      if (busy) busy_total <= busy_total + 1;
      if (done) done_total <= done_total + 1;
      if (bus.sfu_valid_in) begin
         if (!prev_vi) begin
            if (gap_chk_en && rises_total != op_first_rise) chk("gap_len", 32'(lo_run), 32'd1);
            rises_total <= rises_total + 1;
         end
         hi_run <= prev_vi ? hi_run + 1 : 1;
      end else begin
         if (prev_vi && gap_chk_en) chk("burst_len", 32'(hi_run), 32'(exp_acc));
         lo_run <= prev_vi ? 1 : lo_run + 1;
      end
      prev_vi <= bus.sfu_valid_in;
   end

   int snap_done, snap_busy, snap_wr, snap_ren;

   task automatic start_op(input int n, input int a, input logic [10:0] pb, input logic [10:0] ob);
      logic [10:0] ad;
      logic [15:0] acc;
      exp_acc       = a;
      op_first_rise = rises_total;
      gap_chk_en    = 1'b1;
      if (n != 0 && a != 0) begin
         for (int o = 0; o < n; o++) begin
            acc = '0;
            for (int k = 0; k < a; k++) begin
               ad = pb + 11'(o * a + k);
               exp_raddr_q.push_back(ad);
               acc = acc + mem[ad];
            end
            exp_wr_q.push_back({11'(ob + 11'(o)), (acc[15] ? 16'h0000 : acc)});
         end
      end
      snap_done = done_total;
      snap_busy = busy_total;
      snap_wr   = wr_total;
      snap_ren  = ren_total;
      num_out   = 8'(n);
      num_acc   = 8'(a);
      psum_base = pb;
      out_base  = ob;
      start     = 1'b1;
      @(negedge clk);
      start     = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      logic got;
      got = 1'b0;
      for (int i = 0; i < 3000 && !got; i++) begin
         @(negedge clk);
         if (done) got = 1'b1;
      end
      chk({tag, "_done_seen"}, 32'(got), 32'd1);
   endtask

   task automatic finish_op(input string tag, input int n, input int a);
      int nz;
      nz = (n != 0 && a != 0) ? 1 : 0;
      repeat (4) @(negedge clk);
      chk({tag, "_done_cnt"}, 32'(done_total - snap_done), 32'd1);
      chk({tag, "_wr_cnt"}, 32'(wr_total - snap_wr), 32'(nz ? n : 0));
      chk({tag, "_ren_cnt"}, 32'(ren_total - snap_ren), 32'(nz ? n * a : 0));
      chk({tag, "_wr_q_left"}, 32'(exp_wr_q.size()), 32'd0);
      chk({tag, "_busy_cyc"}, 32'(busy_total - snap_busy), 32'(nz ? n * (a + 1) + 4 : 1));
`ifdef SFU_SEQ_CTRL_PERF_EN
      chk({tag, "_perf"}, perf_cycles, 32'(nz ? n * (a + 1) + 4 : 1));
`endif
   endtask

   initial begin
      for (int i = 0; i < 2048; i++) mem[i] = 16'h0000;
      reset = 1'b1; start = 1'b0;
      num_out = '0; num_acc = '0; psum_base = '0; out_base = '0;
      repeat (3) @(negedge clk);
      chk("rst_mem_ren", 32'(bus.mem_ren), 32'd0);
      chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
      chk("rst_valid_in", 32'(bus.sfu_valid_in), 32'd0);
      chk("rst_out_wen", 32'(bus.out_wen), 32'd0);
      chk("rst_out_addr", 32'(bus.out_addr), 32'd0);
      chk("rst_out_wdata", 32'(bus.out_wdata), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // single output, three words
      mem[0] = 16'd5; mem[1] = 16'd7; mem[2] = 16'd2;
      start_op(1, 3, 11'h000, 11'h010);
      wait_done("t1");
      finish_op("t1", 1, 3);

      // three outputs, ReLU clamps the middle one
      mem[11'h020] = 16'd1;    mem[11'h021] = 16'd2;
      mem[11'h022] = 16'hFFF8; mem[11'h023] = 16'd3;
      mem[11'h024] = 16'd4;    mem[11'h025] = 16'd4;
      start_op(3, 2, 11'h020, 11'h040);
      wait_done("t2");
      finish_op("t2", 3, 2);

      // degenerate configs
      start_op(2, 0, 11'h000, 11'h050);
      chk("z1_busy_c0", 32'(busy), 32'd1);
      chk("z1_done_c0", 32'(done), 32'd0);
      @(negedge clk);
      chk("z1_done_c1", 32'(done), 32'd1);
      chk("z1_busy_c1", 32'(busy), 32'd0);
      finish_op("z1", 2, 0);
      start_op(0, 3, 11'h000, 11'h050);
      @(negedge clk);
      chk("z2_done_c1", 32'(done), 32'd1);
      finish_op("z2", 0, 3);

      // address wrap
      mem[11'h7FE] = 16'd1; mem[11'h7FF] = 16'd2; mem[11'h000] = 16'd3; mem[11'h001] = 16'd4;
      start_op(1, 4, 11'h7FE, 11'h060);
      wait_done("t4");
      finish_op("t4", 1, 4);

      // start re-pulsed mid-run
      for (int i = 0; i < 6; i++) mem[11'h100 + 11'(i)] = 16'(i * 3 + 1);
      start_op(3, 2, 11'h100, 11'h200);
      repeat (3) @(negedge clk);
      num_out = 8'd5; num_acc = 8'd1; psum_base = 11'h000; out_base = 11'h300;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done("t5");
      finish_op("t5", 3, 2);

      // reset during READ of output 2 of 4
      for (int i = 0; i < 12; i++) mem[11'h180 + 11'(i)] = 16'(i + 2);
      start_op(4, 3, 11'h180, 11'h280);
      repeat (4) @(negedge clk);
      chk("t6_in_read2_ren", 32'(bus.mem_ren), 32'd1);
      chk("t6_in_read2_addr", 32'(bus.mem_addr), 32'h183);
      gap_chk_en = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      chk("t6_rst_mem_ren", 32'(bus.mem_ren), 32'd0);
      chk("t6_rst_mem_addr", 32'(bus.mem_addr), 32'd0);
      chk("t6_rst_valid_in", 32'(bus.sfu_valid_in), 32'd0);
      chk("t6_rst_out_wen", 32'(bus.out_wen), 32'd0);
      chk("t6_rst_out_addr", 32'(bus.out_addr), 32'd0);
      chk("t6_rst_out_wdata", 32'(bus.out_wdata), 32'd0);
      chk("t6_rst_busy", 32'(busy), 32'd0);
      chk("t6_rst_done", 32'(done), 32'd0);
`ifdef SFU_SEQ_CTRL_PERF_EN
      chk("t6_rst_perf", perf_cycles, 32'd0);
`endif
      exp_raddr_q.delete();
      exp_wr_q.delete();
      reset = 1'b0;
      snap_wr   = wr_total;
      snap_done = done_total;
      snap_ren  = ren_total;
      repeat (12) @(negedge clk);
      chk("t6_no_wr", 32'(wr_total - snap_wr), 32'd0);
      chk("t6_no_done", 32'(done_total - snap_done), 32'd0);
      chk("t6_no_ren", 32'(ren_total - snap_ren), 32'd0);

      // clean run after the abort
      start_op(2, 2, 11'h180, 11'h290);
      wait_done("t7");
      finish_op("t7", 2, 2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
